// File: rtl/riscv_trap_ctrl_if.sv
// Trap-controller bundle: trap requests from the pipeline, the CSR register-file port,
// and the fetch stall/redirect strobes.
interface riscv_trap_ctrl_if #(
    parameter int WORD_LENGTH = 32
);
    logic                   ecall_req;
    logic                   mret_req;
    logic [WORD_LENGTH-1:0] pc_in;
    logic [WORD_LENGTH-1:0] csr_rdata;
    logic                   csr_we;
    logic [WORD_LENGTH-1:0] csr_addr;
    logic [WORD_LENGTH-1:0] csr_wdata;
    logic                   stall;
    logic                   redirect_valid;
    logic [WORD_LENGTH-1:0] redirect_pc;

    // master: the trap controller, which owns the CSR port and the redirect
    modport master (
        input  ecall_req, mret_req, pc_in, csr_rdata,
        output csr_we, csr_addr, csr_wdata, stall, redirect_valid, redirect_pc
    );

    // slave: the pipeline plus CSR register file around the controller
    modport slave (
        output ecall_req, mret_req, pc_in, csr_rdata,
        input  csr_we, csr_addr, csr_wdata, stall, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/riscv_trap_ctrl.sv
// M-mode trap sequencer: ECALL saves mepc/mcause/mstatus and jumps to mtvec;
// MRET restores mstatus and jumps back to mepc. One CSR access per cycle.
module riscv_trap_ctrl #(
    parameter int WORD_LENGTH = 32,
    parameter int ECALL_CAUSE = 11
) (
    input  logic              clk,
    input  logic              rst,
    riscv_trap_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        IDLE,
        SAVE_EPC,
        SAVE_CAUSE,
        SAVE_STATUS,
        LOAD_VEC,
        RESTORE_STATUS,
        LOAD_EPC
    } state_t;

    localparam logic [WORD_LENGTH-1:0] ADDR_MSTATUS = WORD_LENGTH'(12'h300);
    localparam logic [WORD_LENGTH-1:0] ADDR_MTVEC   = WORD_LENGTH'(12'h305);
    localparam logic [WORD_LENGTH-1:0] ADDR_MEPC    = WORD_LENGTH'(12'h341);
    localparam logic [WORD_LENGTH-1:0] ADDR_MCAUSE  = WORD_LENGTH'(12'h342);
    localparam logic [WORD_LENGTH-1:0] ALIGN_MASK   = ~WORD_LENGTH'(3);

    state_t                 r_state;
    state_t                 w_next;
    logic [WORD_LENGTH-1:0] r_epc;
    logic [WORD_LENGTH-1:0] w_status_save;
    logic [WORD_LENGTH-1:0] w_status_restore;
    logic [WORD_LENGTH-1:0] w_target_pc;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would make r_epc depend on process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_epc   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && bus.ecall_req) begin
                r_epc <= bus.pc_in;
            end
        end
    end

    // Entry moves MIE into MPIE; exit moves MPIE back. MPP is always M-mode.
    always_comb begin
        w_status_save           = bus.csr_rdata;
        w_status_save[7]        = bus.csr_rdata[3];
        w_status_save[3]        = 1'b0;
        w_status_save[12:11]    = 2'b11;
        w_status_restore        = bus.csr_rdata;
        w_status_restore[3]     = bus.csr_rdata[7];
        w_status_restore[7]     = 1'b1;
        w_status_restore[12:11] = 2'b11;
        w_target_pc             = bus.csr_rdata & ALIGN_MASK;
    end

    // NOTE: every output and w_next gets a default before the case, so no path
    // through this block can leave a value unassigned and infer a latch.
    always_comb begin
        w_next             = r_state;
        bus.csr_we         = 1'b0;
        bus.csr_addr       = '0;
        bus.csr_wdata      = '0;
        bus.stall          = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        unique case (r_state)
            IDLE: begin
                bus.stall = bus.ecall_req | bus.mret_req;
                if (bus.ecall_req) begin
                    w_next = SAVE_EPC;
                end else if (bus.mret_req) begin
                    w_next = RESTORE_STATUS;
                end
            end
            SAVE_EPC: begin
                bus.csr_we    = 1'b1;
                bus.csr_addr  = ADDR_MEPC;
                bus.csr_wdata = r_epc & ALIGN_MASK;
                w_next        = SAVE_CAUSE;
            end
            SAVE_CAUSE: begin
                bus.csr_we    = 1'b1;
                bus.csr_addr  = ADDR_MCAUSE;
                bus.csr_wdata = WORD_LENGTH'(ECALL_CAUSE);
                w_next        = SAVE_STATUS;
            end
            SAVE_STATUS: begin
                bus.csr_we    = 1'b1;
                bus.csr_addr  = ADDR_MSTATUS;
                bus.csr_wdata = w_status_save;
                w_next        = LOAD_VEC;
            end
            LOAD_VEC: begin
                bus.csr_addr       = ADDR_MTVEC;
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = w_target_pc;
                w_next             = IDLE;
            end
            RESTORE_STATUS: begin
                bus.csr_we    = 1'b1;
                bus.csr_addr  = ADDR_MSTATUS;
                bus.csr_wdata = w_status_restore;
                w_next        = LOAD_EPC;
            end
            LOAD_EPC: begin
                bus.csr_addr       = ADDR_MEPC;
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = w_target_pc;
                w_next             = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end
endmodule
